cpu_debug_ocimem_ctrl: RTL and testbench

CPU_DEBUG_OCIMEM_CTRL -- requirements
Module: cpu_debug_ocimem_ctrl

---
 rtl/cpu_debug_ocimem_pkg.sv | 24 ++
 rtl/cpu_debug_ocimem_ram.sv | 26 ++
 rtl/cpu_debug_ocimem_ctrl.sv | 112 +++++++++++
 tb/tb_cpu_debug_ocimem_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_debug_ocimem_pkg.sv
// Shared definitions for the debug on-chip memory controller: FSM states
// and the JTAG data-word field positions.
package cpu_debug_ocimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_J_RD = 2'd1,
    ST_C_RD = 2'd2
  } ocimem_state_t;

  localparam int OCIMEM_DEPTH = 256;
  localparam int OCIMEM_AW    = 8;

  localparam int JDO_ADDR_LSB = 18;
  localparam int JDO_RDFLAG   = 34;
  localparam int JDO_ERRCLR   = 35;
  localparam int JDO_DATA_LSB = 3;

  // True when exactly one of the three JTAG action pulses is asserted.
  function automatic logic single_pulse(input logic [2:0] p);
    return (p == 3'b001) || (p == 3'b010) || (p == 3'b100);
  endfunction

endpackage

// File: rtl/cpu_debug_ocimem_ram.sv
// Single-port debug RAM: 32-bit words, byte-lane writes, registered read
// that returns the old word when a write hits the same address.
module cpu_debug_ocimem_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int MEM_AW    = 8
) (
  input  logic              clk,
  input  logic [MEM_AW-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/cpu_debug_ocimem_ctrl.sv
// Debug on-chip memory controller: arbitrates JTAG monitor accesses and CPU
// slave accesses onto one single-port RAM, JTAG taking priority.
module cpu_debug_ocimem_ctrl
  import cpu_debug_ocimem_pkg::*;
#(
  parameter int MEM_DEPTH = OCIMEM_DEPTH,
  parameter int MEM_AW    = OCIMEM_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [MEM_AW-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  ocimem_state_t     state;
  logic [MEM_AW-1:0] mon_a_reg;
  logic [2:0]        pulses;
  logic              any_pulse, idle, jtag_ok, cpu_wr_acc, cpu_rd_acc, cpu_rd_done;
  logic [MEM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata, ram_rdata_p1;
  logic              unused_jdo;

  assign pulses     = {take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a};
  assign any_pulse  = |pulses;
  assign idle       = (state == ST_IDLE);
  assign jtag_ok    = !reset && idle && single_pulse(pulses);
  assign cpu_wr_acc = !reset && idle && !any_pulse && write;
  assign cpu_rd_acc = !reset && idle && !any_pulse && !write && read;
  assign cpu_rd_done = !reset && (state == ST_C_RD) && read;

  assign monitor_ready = idle;
  assign waitrequest   = !reset && (read || write) && !(cpu_wr_acc || cpu_rd_done);
  assign readdata      = (state == ST_C_RD) ? ram_rdata_p1 : 32'd0;
  assign unused_jdo    = ^jdo;

  // Address load reads the new address directly so J_RD sees its word.
  always_comb begin
    ram_addr  = address;
    ram_we    = 1'b0;
    ram_be    = 4'hF;
    ram_wdata = writedata;
    if (jtag_ok) begin
      ram_addr  = take_action_ocimem_a ? jdo[JDO_ADDR_LSB +: MEM_AW] : mon_a_reg;
      ram_wdata = jdo[JDO_DATA_LSB +: 32];
      ram_we    = take_action_ocimem_b;
    end else if (cpu_wr_acc) begin
      ram_we = debugaccess;
      ram_be = byteenable;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      mon_a_reg     <= '0;
      MonDReg       <= 32'd0;
      monitor_error <= 1'b0;
    end else begin
      if (any_pulse && !(idle && single_pulse(pulses))) monitor_error <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (jtag_ok) begin
            if (take_action_ocimem_a) begin
              mon_a_reg <= jdo[JDO_ADDR_LSB +: MEM_AW];
              if (jdo[JDO_ERRCLR]) monitor_error <= 1'b0;
              if (jdo[JDO_RDFLAG]) state <= ST_J_RD;
            end else begin
              mon_a_reg <= mon_a_reg + MEM_AW'(1);
              if (take_no_action_ocimem_a) state <= ST_J_RD;
            end
          end else if (cpu_rd_acc) begin
            state <= ST_C_RD;
          end
        end
        ST_J_RD: begin
          MonDReg <= ram_rdata_p1;
          state   <= ST_IDLE;
        end
        ST_C_RD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  cpu_debug_ocimem_ram #(
    .MEM_DEPTH(MEM_DEPTH),
    .MEM_AW   (MEM_AW)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .be   (ram_be),
    .wdata(ram_wdata),
    .rdata(ram_rdata_p1)
  );

endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// Randomized bench for cpu_debug_ocimem_ctrl with a word-array memory model
// tracking RAM contents, the JTAG address register and the error flag.
module tb_cpu_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [7:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        debugaccess = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int total = 0;
  int bad = 0;

  logic [31:0] ref_mem [256];
  int          ref_addr = 0;

  always #5 clk = ~clk;

  cpu_debug_ocimem_ctrl #(.MEM_DEPTH(256), .MEM_AW(8)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .debugaccess(debugaccess),
    .readdata(readdata), .waitrequest(waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [37:0] jdo_a(input int addr, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[25:18] = addr[7:0];
    j[34] = rd;
    j[35] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    return j;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] j);
    take_action_ocimem_a = a;
    take_action_ocimem_b = b;
    take_no_action_ocimem_a = na;
    jdo = j;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic set_addr(input int addr);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(addr, 1'b0, 1'b0));
    ref_addr = addr;
  endtask

  task automatic jtag_write(input logic [31:0] data);
    pulse(1'b0, 1'b1, 1'b0, jdo_b(data));
    ref_mem[ref_addr] = data;
    ref_addr = (ref_addr + 1) % 256;
  endtask

  // Returns monitor_ready one cycle after the pulse, then MonDReg/ready a cycle later.
  task automatic jtag_read_at(input int addr, output logic rdy_mid, output logic [31:0] d,
                              output logic rdy_end);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(addr, 1'b1, 1'b0));
    ref_addr = addr;
    rdy_mid = monitor_ready;
    tick();
    rdy_end = monitor_ready;
    d = MonDReg;
  endtask

  task automatic jtag_read_next(output logic rdy_mid, output logic [31:0] d, output logic rdy_end);
    pulse(1'b0, 1'b0, 1'b1, '0);
    rdy_mid = monitor_ready;
    tick();
    rdy_end = monitor_ready;
    d = MonDReg;
  endtask

  task automatic cpu_write(input int addr, input logic [31:0] data, input logic [3:0] be,
                           input logic dbg, output logic wr);
    address = addr[7:0];
    writedata = data;
    byteenable = be;
    debugaccess = dbg;
    write = 1'b1;
    #1;
    wr = waitrequest;
    tick();
    write = 1'b0;
    if (dbg) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[addr][8*i +: 8] = data[8*i +: 8];
    end
  endtask

  task automatic cpu_read(input int addr, output logic w0, output logic w1, output logic [31:0] d);
    address = addr[7:0];
    read = 1'b1;
    #1;
    w0 = waitrequest;
    tick();
    w1 = waitrequest;
    d = readdata;
    read = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (monitor_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", monitor_ready); end
    total++;
    if (MonDReg !== 32'd0) begin bad++; $display("FAIL reset_mondreg: got %h want 0", MonDReg); end
    total++;
    if (monitor_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", monitor_error); end
    total++;
    if (waitrequest !== 1'b0) begin bad++; $display("FAIL reset_wait: got %b want 0", waitrequest); end
    total++;
    if (readdata !== 32'd0) begin bad++; $display("FAIL reset_readdata: got %h want 0", readdata); end
    reset = 1'b0;
    tick();
    ref_addr = 0;
  endtask

  task automatic test_fill_and_read();
    logic rm, re;
    logic [31:0] d;
    int a;
    set_addr(0);
    for (int i = 0; i < 256; i++) jtag_write($urandom);
    total++;
    if (monitor_error !== 1'b0) begin bad++; $display("FAIL fill_error: got %b want 0", monitor_error); end
    for (int k = 0; k < 12; k++) begin
      a = $urandom_range(0, 255);
      jtag_read_at(a, rm, d, re);
      total++;
      if (rm !== 1'b0 || re !== 1'b1 || d !== ref_mem[a]) begin
        bad++;
        $display("FAIL jtag_rand_read @%0d: got rdy %b/%b data %h want 0/1 %h", a, rm, re, d, ref_mem[a]);
      end
    end
  endtask

  task automatic test_basic_sequence();
    logic rm, re;
    logic [31:0] d;
    set_addr(16);
    jtag_write(32'hDEADBEEF);
    jtag_read_at(16, rm, d, re);
    total++;
    if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_mondreg: got %h want deadbeef", d); end
    total++;
    if (rm !== 1'b0 || re !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b/%b want 0/1", rm, re); end
  endtask

  task automatic test_wrap();
    logic rm, re;
    logic [31:0] d;
    set_addr(255);
    jtag_write(32'h11111111);
    jtag_write(32'h22222222);
    total++;
    if (monitor_error !== 1'b0) begin bad++; $display("FAIL wrap_error: got %b want 0", monitor_error); end
    jtag_read_at(255, rm, d, re);
    total++;
    if (d !== 32'h11111111) begin bad++; $display("FAIL wrap_ff: got %h want 11111111", d); end
    jtag_read_at(0, rm, d, re);
    total++;
    if (d !== 32'h22222222) begin bad++; $display("FAIL wrap_00: got %h want 22222222", d); end
  endtask

  task automatic test_protocol_errors();
    logic rm, re;
    logic [31:0] d;
    logic [31:0] exp;
    int a;
    a = $urandom_range(0, 250);
    set_addr(a);
    pulse(1'b0, 1'b0, 1'b1, '0);
    pulse(1'b0, 1'b0, 1'b1, '0);
    total++;
    if (monitor_error !== 1'b1) begin bad++; $display("FAIL busy_error: got %b want 1", monitor_error); end
    total++;
    if (MonDReg !== ref_mem[a]) begin bad++; $display("FAIL busy_mondreg: got %h want %h", MonDReg, ref_mem[a]); end
    ref_addr = a + 1;
    exp = ref_mem[ref_addr];
    jtag_read_next(rm, d, re);
    ref_addr = ref_addr + 1;
    total++;
    if (d !== exp) begin bad++; $display("FAIL busy_ignored: got %h want %h", d, exp); end
    pulse(1'b1, 1'b0, 1'b0, jdo_a(a, 1'b0, 1'b1));
    ref_addr = a;
    total++;
    if (monitor_error !== 1'b0) begin bad++; $display("FAIL errclr: got %b want 0", monitor_error); end
    // Two pulses at once: nothing written, address unchanged.
    pulse(1'b1, 1'b1, 1'b0, jdo_a((a + 3) % 256, 1'b0, 1'b0) | jdo_b(~ref_mem[a]));
    total++;
    if (monitor_error !== 1'b1) begin bad++; $display("FAIL multi_error: got %b want 1", monitor_error); end
    exp = ref_mem[a];
    jtag_read_next(rm, d, re);
    ref_addr = ref_addr + 1;
    total++;
    if (d !== exp) begin bad++; $display("FAIL multi_ignored: got %h want %h", d, exp); end
    pulse(1'b1, 1'b0, 1'b0, jdo_a(0, 1'b0, 1'b1));
    ref_addr = 0;
  endtask

  task automatic test_cpu_access();
    logic wr, w0, w1;
    logic [31:0] d;
    int a;
    set_addr(4);
    jtag_write(32'h0);
    cpu_write(4, 32'hA5A5A5A5, 4'b0011, 1'b1, wr);
    total++;
    if (wr !== 1'b0) begin bad++; $display("FAIL cpu_wr_wait: got %b want 0", wr); end
    cpu_read(4, w0, w1, d);
    total++;
    if (w0 !== 1'b1 || w1 !== 1'b0) begin bad++; $display("FAIL cpu_rd_wait: got %b/%b want 1/0", w0, w1); end
    total++;
    if (d !== 32'h0000A5A5) begin bad++; $display("FAIL cpu_be_read: got %h want 0000a5a5", d); end
    cpu_write(4, 32'h5A5A5A5A, 4'b0011, 1'b0, wr);
    total++;
    if (wr !== 1'b0) begin bad++; $display("FAIL cpu_nodbg_wait: got %b want 0", wr); end
    cpu_read(4, w0, w1, d);
    total++;
    if (d !== 32'h0000A5A5) begin bad++; $display("FAIL cpu_nodbg_drop: got %h want 0000a5a5", d); end
    for (int k = 0; k < 16; k++) begin
      cpu_write($urandom_range(0, 255), $urandom, 4'($urandom), 1'($urandom), wr);
      a = $urandom_range(0, 255);
      cpu_read(a, w0, w1, d);
      total++;
      if (w0 !== 1'b1 || w1 !== 1'b0 || d !== ref_mem[a]) begin
        bad++;
        $display("FAIL cpu_rand @%0d: got wait %b/%b data %h want 1/0 %h", a, w0, w1, d, ref_mem[a]);
      end
    end
  endtask

  task automatic test_collision();
    logic w0, w1, w2;
    logic [31:0] d, nd;
    int a;
    a = $urandom_range(0, 255);
    nd = $urandom;
    set_addr(a);
    address = a[7:0];
    read = 1'b1;
    take_action_ocimem_b = 1'b1;
    jdo = jdo_b(nd);
    #1;
    w0 = waitrequest;
    tick();
    take_action_ocimem_b = 1'b0;
    ref_mem[a] = nd;
    ref_addr = (a + 1) % 256;
    #1;
    w1 = waitrequest;
    tick();
    w2 = waitrequest;
    d = readdata;
    read = 1'b0;
    tick();
    total++;
    if (w0 !== 1'b1 || w1 !== 1'b1 || w2 !== 1'b0) begin
      bad++; $display("FAIL collide_wait: got %b%b%b want 110", w0, w1, w2);
    end
    total++;
    if (d !== nd) begin bad++; $display("FAIL collide_data: got %h want %h", d, nd); end
  endtask

  task automatic test_reset_priority();
    logic rm, re, w0, w1;
    logic [31:0] d;
    logic [31:0] e0;
    jtag_read_at(33, rm, d, re);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(68, 1'b1, 1'b0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ref_addr = 0;
    #1;
    total++;
    if (monitor_ready !== 1'b1) begin bad++; $display("FAIL rst_jrd_ready: got %b want 1", monitor_ready); end
    total++;
    if (MonDReg !== 32'd0) begin bad++; $display("FAIL rst_jrd_mondreg: got %h want 0", MonDReg); end
    // Reset beats a JTAG write and a CPU write issued in the same cycle.
    reset = 1'b1;
    take_action_ocimem_b = 1'b1;
    jdo = jdo_b(~ref_mem[0]);
    write = 1'b1;
    address = 8'd7;
    writedata = ~ref_mem[7];
    byteenable = 4'hF;
    debugaccess = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    write = 1'b0;
    reset = 1'b0;
    tick();
    cpu_read(7, w0, w1, d);
    total++;
    if (d !== ref_mem[7]) begin bad++; $display("FAIL rst_cpu_wr: got %h want %h", d, ref_mem[7]); end
    e0 = ref_mem[0];
    jtag_read_next(rm, d, re);
    ref_addr = 1;
    total++;
    if (d !== e0) begin bad++; $display("FAIL rst_mona_zero: got %h want %h", d, e0); end
  endtask

  initial begin
    test_reset();
    test_fill_and_read();
    test_basic_sequence();
    test_wrap();
    test_protocol_errors();
    test_cpu_access();
    test_collision();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
